// File: rtl/sha1_pkg.sv
// Shared constants, FSM encoding and a last-word padding helper for the SHA-1 message sequencer.
package sha1_pkg;
  localparam int BLOCK_WORDS = 16;

  localparam logic [31:0] IV_H0 = 32'h67452301;
  localparam logic [31:0] IV_H1 = 32'hEFCDAB89;
  localparam logic [31:0] IV_H2 = 32'h98BADCFE;
  localparam logic [31:0] IV_H3 = 32'h10325476;
  localparam logic [31:0] IV_H4 = 32'hC3D2E1F0;
  localparam logic [159:0] IV = {IV_H0, IV_H1, IV_H2, IV_H3, IV_H4};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PAD,
    ST_LAUNCH,
    ST_WAIT,
    ST_FINAL
  } state_t;

  // Keep the first n bytes (MSB-aligned), place 0x80 at byte n, zero the rest; n is 1..3.
  function automatic logic [31:0] pad_last_word(input logic [31:0] d, input logic [1:0] n);
    logic [31:0] r;
    r = d;
    for (int k = 0; k < 4; k++) begin
      if (k == int'(n)) r[31-8*k -: 8] = 8'h80;
      else if (k > int'(n)) r[31-8*k -: 8] = 8'h00;
    end
    return r;
  endfunction
endpackage

// File: rtl/sha1_core.sv
// SHA-1 compression of one 512-bit block: one round per cycle, o_done 81 cycles after i_start.
// i_vin is added back at the end, so it must stay stable until o_done.
module sha1_core
  import sha1_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [511:0] i_data,
  input  logic [159:0] i_vin,
  output logic         o_done,
  output logic [159:0] o_vout
);
  logic [31:0] w [BLOCK_WORDS];
  logic [31:0] a, b, c, d, e;
  logic [6:0]  t;
  logic        run, fin;
  logic [31:0] f, k, tmp, wx, wnext;

  always_comb begin
    f = b ^ c ^ d;
    k = 32'hCA62C1D6;
    if (t < 7'd20) begin
      f = (b & c) | (~b & d);
      k = 32'h5A827999;
    end else if (t < 7'd40) begin
      k = 32'h6ED9EBA1;
    end else if (t < 7'd60) begin
      f = (b & c) | (b & d) | (c & d);
      k = 32'h8F1BBCDC;
    end
    tmp   = {a[26:0], a[31:27]} + f + e + k + w[0];
    // w[] is a sliding window: w[0] is W[t], w[15] is W[t+15]
    wx    = w[13] ^ w[8] ^ w[2] ^ w[0];
    wnext = {wx[30:0], wx[31]};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < BLOCK_WORDS; i++) w[i] <= '0;
      {a, b, c, d, e} <= '0;
      t      <= '0;
      run    <= 1'b0;
      fin    <= 1'b0;
      o_done <= 1'b0;
      o_vout <= '0;
    end else begin
      o_done <= 1'b0;
      if (i_start) begin
        for (int i = 0; i < BLOCK_WORDS; i++) w[i] <= i_data[511-32*i -: 32];
        {a, b, c, d, e} <= i_vin;
        t   <= '0;
        run <= 1'b1;
        fin <= 1'b0;
      end else if (run) begin
        e <= d;
        d <= c;
        c <= {b[1:0], b[31:2]};
        b <= a;
        a <= tmp;
        for (int i = 0; i < BLOCK_WORDS - 1; i++) w[i] <= w[i+1];
        w[BLOCK_WORDS-1] <= wnext;
        t <= t + 7'd1;
        if (t == 7'd79) begin
          run <= 1'b0;
          fin <= 1'b1;
        end
      end else if (fin) begin
        fin    <= 1'b0;
        o_done <= 1'b1;
        o_vout <= {i_vin[159:128] + a, i_vin[127:96] + b, i_vin[95:64] + c,
                   i_vin[63:32] + d, i_vin[31:0] + e};
      end
    end
  end
endmodule

// File: rtl/sha1_ctrl.sv
// Message-level SHA-1 sequencer: buffers 32-bit words into blocks, pads and appends the length,
// runs sha1_core once per block and chains the hash; o_ready depends on FSM state only.
module sha1_ctrl
  import sha1_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_init,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [31:0]  i_data,
  input  logic         i_last,
  input  logic [1:0]   i_bytes,
  output logic         o_busy,
  output logic [159:0] o_digest,
  output logic         o_done
);
  state_t             state, state_nx;
  logic [31:0]        blk [BLOCK_WORDS];
  logic [3:0]         widx;
  logic [LEN_W-1:0]   len;
  logic [159:0]       h;
  logic               pad80_done, final_blk, msg_end;
  logic [63:0]        len64;
  logic [5:0]         incr;
  logic [31:0]        fill;
  logic               core_start, core_done;
  logic [511:0]       core_data;
  logic [159:0]       core_vout;

  assign o_ready    = (state == ST_LOAD);
  assign o_busy     = (state != ST_IDLE);
  assign o_done     = (state == ST_FINAL);
  assign o_digest   = h;
  assign core_start = (state == ST_LAUNCH);
  assign len64      = 64'(len);
  assign fill       = pad80_done ? 32'h0 : 32'h8000_0000;

  always_comb begin
    incr = 6'd32;
    if (i_last && i_bytes != 2'd0) incr = {1'b0, i_bytes, 3'b000};
  end

  always_comb begin
    core_data = '0;
    for (int i = 0; i < BLOCK_WORDS; i++) core_data[511-32*i -: 32] = blk[i];
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (i_init) state_nx = ST_LOAD;
      ST_LOAD: begin
        if (i_valid) begin
          // A message ending in word 15 has no room left; launch and pad in a fresh block.
          if (widx == 4'd15) state_nx = ST_LAUNCH;
          else if (i_last)   state_nx = ST_PAD;
        end
      end
      ST_PAD:    if (widx >= 4'd14) state_nx = ST_LAUNCH;
      ST_LAUNCH: state_nx = ST_WAIT;
      ST_WAIT: begin
        if (core_done) begin
          if (final_blk)    state_nx = ST_FINAL;
          else if (msg_end) state_nx = ST_PAD;
          else              state_nx = ST_LOAD;
        end
      end
      ST_FINAL:  state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BLOCK_WORDS; i++) blk[i] <= '0;
      widx       <= '0;
      len        <= '0;
      h          <= '0;
      pad80_done <= 1'b0;
      final_blk  <= 1'b0;
      msg_end    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_init) begin
            h          <= IV;
            len        <= '0;
            widx       <= '0;
            pad80_done <= 1'b0;
            final_blk  <= 1'b0;
            msg_end    <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (i_valid) begin
            blk[widx] <= (i_last && i_bytes != 2'd0) ? pad_last_word(i_data, i_bytes) : i_data;
            widx      <= widx + 4'd1;
            len       <= len + LEN_W'(incr);
            final_blk <= 1'b0;
            if (i_last) begin
              msg_end    <= 1'b1;
              pad80_done <= (i_bytes != 2'd0);
            end
          end
        end
        ST_PAD: begin
          if (widx < 4'd14) begin
            blk[widx]  <= fill;
            pad80_done <= 1'b1;
            widx       <= widx + 4'd1;
          end else if (widx == 4'd14 && pad80_done) begin
            blk[14]   <= len64[63:32];
            blk[15]   <= len64[31:0];
            final_blk <= 1'b1;
          end else begin
            // Length no longer fits: close this block and pad again from word 0.
            blk[widx] <= fill;
            if (widx == 4'd14) blk[15] <= 32'h0;
            pad80_done <= 1'b1;
            final_blk  <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (core_done) begin
            h    <= core_vout;
            widx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  sha1_core u_core (
    .i_clk   (i_clk),
    .i_rst   (~i_rst_n),
    .i_start (core_start),
    .i_data  (core_data),
    .i_vin   (h),
    .o_done  (core_done),
    .o_vout  (core_vout)
  );
endmodule

// File: tb/tb_sha1_ctrl.sv
// Self-checking bench for sha1_ctrl: message table, random gapped traffic, reset abort.
module tb_sha1_ctrl;
  import sha1_pkg::*;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_init = 1'b0;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [31:0]  i_data = '0;
  logic         i_last = 1'b0;
  logic [1:0]   i_bytes = '0;
  logic         o_busy;
  logic [159:0] o_digest;
  logic         o_done;

  sha1_ctrl #(.LEN_W(64)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_init(i_init), .i_valid(i_valid),
    .o_ready(o_ready), .i_data(i_data), .i_last(i_last), .i_bytes(i_bytes),
    .o_busy(o_busy), .o_digest(o_digest), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [159:0] digest;
    int           launches;
  } sb_t;

  typedef struct {
    string        txt;
    int           n;
    logic [159:0] known;
    int           launches;
    bit           chk_blk;
    logic [511:0] last_blk;
  } vec_t;

  sb_t          sb_q[$];
  int           checks = 0;
  int           failures = 0;
  int           launch_total = 0;
  logic [511:0] launch_log [256];
  vec_t         tv [10];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] sha1_sw(input logic [7:0] m[$]);
    logic [7:0]  p[$];
    logic [31:0] w [80];
    logic [31:0] hh [5];
    logic [31:0] a, b, c, d, e, f, k, tmp;
    logic [63:0] bl;
    hh[0] = 32'h67452301; hh[1] = 32'hEFCDAB89; hh[2] = 32'h98BADCFE;
    hh[3] = 32'h10325476; hh[4] = 32'hC3D2E1F0;
    p = m;
    bl = 64'(m.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[i*8 +: 8]);
    for (int blk = 0; blk < p.size() / 64; blk++) begin
      for (int t = 0; t < 16; t++)
        w[t] = {p[blk*64+4*t], p[blk*64+4*t+1], p[blk*64+4*t+2], p[blk*64+4*t+3]};
      for (int t = 16; t < 80; t++) begin
        tmp  = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
        w[t] = {tmp[30:0], tmp[31]};
      end
      a = hh[0]; b = hh[1]; c = hh[2]; d = hh[3]; e = hh[4];
      for (int t = 0; t < 80; t++) begin
        if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
        else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
        else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
        else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
        tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
        e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
      end
      hh[0] += a; hh[1] += b; hh[2] += c; hh[3] += d; hh[4] += e;
    end
    return {hh[0], hh[1], hh[2], hh[3], hh[4]};
  endfunction

  task automatic monitor();
    sb_t ex;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && dut.u_core.i_start) begin
        launch_log[launch_total % 256] = dut.u_core.i_data;
        launch_total++;
      end
      if (o_done) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got o_done=1 expected no completion");
        end else begin
          ex = sb_q.pop_front();
          check("digest", o_digest, ex.digest);
          check("launches", 160'(launch_total), 160'(ex.launches));
        end
      end
    end
  endtask

  task automatic start_msg(input logic [7:0] m[$], input logic [159:0] exp, input int launches,
                           input bit gaps, input bit spam);
    int          nw;
    int          budget;
    int          idx;
    logic [31:0] wd;
    sb_t         ex;
    nw = (m.size() + 3) / 4;
    @(negedge i_clk);
    i_init = 1'b1;
    @(negedge i_clk);
    i_init = 1'b0;
    ex.digest   = exp;
    ex.launches = launch_total + launches;
    sb_q.push_back(ex);
    check("busy_after_init", 160'(o_busy), 160'(1));
    for (int j = 0; j < nw; j++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          i_valid = 1'b0;
          if (spam) i_init = 1'($urandom_range(0, 1));
          @(negedge i_clk);
        end
      end
      for (int bb = 0; bb < 4; bb++) begin
        idx = 4 * j + bb;
        wd[31-8*bb -: 8] = (idx < m.size()) ? m[idx] : 8'hEE;
      end
      i_data  = wd;
      i_last  = (j == nw - 1);
      i_bytes = (j == nw - 1) ? 2'(m.size() % 4) : 2'($urandom_range(0, 3));
      i_valid = 1'b1;
      budget = 0;
      while (!o_ready && budget < 1000) begin
        if (spam) i_init = 1'($urandom_range(0, 1));
        @(negedge i_clk);
        budget++;
      end
      if (budget >= 1000) begin
        checks++;
        failures++;
        $display("FAIL ready_timeout: got o_ready=0 for %0d cycles expected 1", budget);
      end
      @(negedge i_clk);
      i_valid = 1'b0;
      i_last  = 1'b0;
      i_init  = 1'b0;
    end
  endtask

  task automatic wait_done(input logic [159:0] exp);
    int budget;
    budget = 0;
    while (sb_q.size() != 0 && budget < 4000) begin
      @(negedge i_clk);
      budget++;
    end
    if (budget >= 4000) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no o_done in %0d cycles expected o_done", budget);
      sb_q.delete();
    end
    repeat (3) @(negedge i_clk);
    check("busy_after_done", 160'(o_busy), 160'(0));
    check("digest_hold", o_digest, exp);
  endtask

  initial begin
    logic [7:0]   m[$];
    logic [159:0] exp;
    int           n;
    int           budget;

    fork
      monitor();
    join_none

    tv[0] = '{"abc", 3, 160'ha9993e364706816aba3e25717850c26c9cd0d89d, 1, 1'b0, '0};
    tv[1] = '{"a", 1, 160'h86f7e437faa5a7fce15d1ddcb9eaeaea377667b8, 1, 1'b0, '0};
    tv[2] = '{"abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", 56,
              160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1, 2, 1'b1, {448'b0, 64'h1C0}};
    tv[3] = '{"", 64, '0, 2, 1'b1, {32'h8000_0000, 416'b0, 64'h200}};
    tv[4] = '{"", 55, '0, 1, 1'b0, '0};
    tv[5] = '{"", 52, '0, 1, 1'b0, '0};
    tv[6] = '{"", 53, '0, 1, 1'b0, '0};
    tv[7] = '{"", 57, '0, 2, 1'b0, '0};
    tv[8] = '{"", 61, '0, 2, 1'b0, '0};
    tv[9] = '{"", 63, '0, 2, 1'b0, '0};

    repeat (3) @(negedge i_clk);
    check("rst_ready", 160'(o_ready), 160'(0));
    check("rst_busy", 160'(o_busy), 160'(0));
    check("rst_done", 160'(o_done), 160'(0));
    check("rst_digest", o_digest, 160'(0));
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    for (int v = 0; v < 10; v++) begin
      m.delete();
      if (tv[v].txt.len() > 0) begin
        for (int i = 0; i < tv[v].txt.len(); i++) m.push_back(tv[v].txt[i]);
      end else begin
        for (int i = 0; i < tv[v].n; i++) m.push_back(8'(i * 37 + 11));
      end
      exp = (tv[v].known != '0) ? tv[v].known : sha1_sw(m);
      start_msg(m, exp, tv[v].launches, 1'b0, 1'b0);
      wait_done(exp);
      if (tv[v].chk_blk)
        check("last_block", launch_log[(launch_total - 1) % 256][159:0], tv[v].last_blk[159:0]);
      if (tv[v].chk_blk)
        check("last_block_hi", launch_log[(launch_total - 1) % 256][511:352], tv[v].last_blk[511:352]);
    end

    for (int r = 0; r < 6; r++) begin
      m.delete();
      n = $urandom_range(1, 150);
      for (int i = 0; i < n; i++) m.push_back(8'($urandom_range(0, 255)));
      exp = sha1_sw(m);
      start_msg(m, exp, (n + 8) / 64 + 1, 1'b1, 1'b1);
      wait_done(exp);
    end

    m.delete();
    m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63);
    start_msg(m, 160'ha9993e364706816aba3e25717850c26c9cd0d89d, 1, 1'b0, 1'b0);
    budget = 0;
    while (dut.state != ST_WAIT && budget < 200) begin
      @(negedge i_clk);
      budget++;
    end
    check("reached_wait", 160'(dut.state == ST_WAIT), 160'(1));
    repeat (10) @(negedge i_clk);
    i_rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("abort_ready", 160'(o_ready), 160'(0));
    check("abort_busy", 160'(o_busy), 160'(0));
    check("abort_done", 160'(o_done), 160'(0));
    check("abort_digest", o_digest, 160'(0));
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (150) @(negedge i_clk);
    start_msg(m, 160'ha9993e364706816aba3e25717850c26c9cd0d89d, 1, 1'b1, 1'b0);
    wait_done(160'ha9993e364706816aba3e25717850c26c9cd0d89d);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
